player_input_ctrl: RTL and testbench

- Producer side of the player-control interface consumed by the VGA display top.
- Debounces the raw left, right and fire buttons.
- Maintains the player column position and drives it on btn_col.
- Allocates and retires the 8 missile slots on btn_missle_en.
- All motion and missile timing advances once per video frame, derived from the vertical sync.

---
 rtl/player_ctrl_pkg.sv | 31 +++
 rtl/btn_debounce.sv | 41 ++++
 rtl/player_input_ctrl.sv | 148 ++++++++++++++
 tb/tb_player_input_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/player_ctrl_pkg.sv
// Shared widths, slot index type and the lowest-free-slot search used by the
// player input controller.
package player_ctrl_pkg;

  localparam int NUM_MISSILES = 8;
  localparam int COL_W        = 12;
  localparam int LIFE_W       = 7;

  typedef logic [2:0]        slot_idx_t;
  typedef logic [LIFE_W-1:0] life_t;

  typedef struct packed {
    logic      found;
    slot_idx_t idx;
  } free_slot_t;

  // Scans high to low so the last hit, and therefore the result, is the lowest free index.
  function automatic free_slot_t find_free_slot(input logic [NUM_MISSILES-1:0] en);
    free_slot_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = NUM_MISSILES - 1; i >= 0; i--) begin
      if (!en[i]) begin
        r.found = 1'b1;
        r.idx   = slot_idx_t'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-state debouncer: the output flips
// only after DEBOUNCE_CYCLES consecutive clocks of disagreement.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic vga_clk_i,
  input  logic vga_rst_i,
  input  logic btn_raw,
  output logic btn_stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge vga_clk_i) begin
    if (vga_rst_i) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      btn_stable <= 1'b0;
      cnt        <= '0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
      if (sync_2 != btn_stable) begin
        if (cnt == CNT_LAST) begin
          btn_stable <= sync_2;
          cnt        <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/player_input_ctrl.sv
// Player control producer: debounced buttons, frame-rate column motion and
// 8-slot missile allocation. Define AUTOFIRE_EN to re-fire while fire is held.
module player_input_ctrl
  import player_ctrl_pkg::*;
#(
  parameter int unsigned      DEBOUNCE_CYCLES = 250000,
  parameter logic [COL_W-1:0] COL_MIN         = 12'd16,
  parameter logic [COL_W-1:0] COL_MAX         = 12'd608,
  parameter logic [COL_W-1:0] COL_RESET       = 12'd312,
  parameter int               STEP            = 4,
  parameter int               MISSILE_FRAMES  = 120,
  parameter int               FIRE_COOLDOWN   = 15,
  parameter bit               VS_ACTIVE_LOW   = 1'b1
) (
  input  logic                    vga_clk_i,
  input  logic                    vga_rst_i,
  input  logic                    vga_vs,
  input  logic                    btn_left_i,
  input  logic                    btn_right_i,
  input  logic                    btn_fire_i,
  output logic [COL_W-1:0]        btn_col,
  output logic [NUM_MISSILES-1:0] btn_missle_en,
  output logic                    launch_pulse,
  output logic [2:0]              launch_slot,
  output logic                    shot_dropped
);

  typedef logic signed [COL_W:0] scol_t;

  logic left_db, right_db, fire_db;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .vga_clk_i(vga_clk_i), .vga_rst_i(vga_rst_i), .btn_raw(btn_left_i), .btn_stable(left_db)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .vga_clk_i(vga_clk_i), .vga_rst_i(vga_rst_i), .btn_raw(btn_right_i), .btn_stable(right_db)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fire (
    .vga_clk_i(vga_clk_i), .vga_rst_i(vga_rst_i), .btn_raw(btn_fire_i), .btn_stable(fire_db)
  );

  logic  vs_s1, vs_s2, vs_d, vs_edge, tick;
  logic  fire_prev, fire_rise;
  life_t life [NUM_MISSILES];
  life_t cooldown;
  logic  pending;

  // Tick is registered, giving two clocks from the synchronized vs edge to the outputs.
  assign vs_edge   = VS_ACTIVE_LOW ? (vs_d & ~vs_s2) : (~vs_d & vs_s2);
  assign fire_rise = fire_db & ~fire_prev;

  logic [COL_W-1:0] col_n;
  scol_t            col_dec, col_inc;

  always_comb begin
    col_n   = btn_col;
    col_dec = scol_t'({1'b0, btn_col}) - scol_t'(STEP);
    col_inc = scol_t'({1'b0, btn_col}) + scol_t'(STEP);
    if (tick) begin
      if (left_db && !right_db) begin
        col_n = (col_dec < scol_t'({1'b0, COL_MIN})) ? COL_MIN : col_dec[COL_W-1:0];
      end else if (right_db && !left_db) begin
        col_n = (col_inc > scol_t'({1'b0, COL_MAX})) ? COL_MAX : col_inc[COL_W-1:0];
      end
    end
  end

  logic [NUM_MISSILES-1:0] en_n;
  life_t                   life_n [NUM_MISSILES];
  life_t                   cd_n;
  logic                    pend_n, fire_req, lp_n, drop_n;
  slot_idx_t               slot_n;
  free_slot_t              free_s;

  // Tick order: age slots, age cooldown, then serve the pending shot against the aged slots.
  always_comb begin
    en_n     = btn_missle_en;
    life_n   = life;
    cd_n     = cooldown;
    pend_n   = pending;
    fire_req = 1'b0;
    lp_n     = 1'b0;
    drop_n   = 1'b0;
    slot_n   = '0;
    free_s   = '0;
    if (tick) begin
      for (int i = 0; i < NUM_MISSILES; i++) begin
        if (btn_missle_en[i]) begin
          life_n[i] = life[i] - life_t'(1);
          if (life_n[i] == '0) en_n[i] = 1'b0;
        end
      end
      if (cooldown != '0) cd_n = cooldown - life_t'(1);
`ifdef AUTOFIRE_EN
      fire_req = pending | (fire_db & (cd_n == '0));
`else
      fire_req = pending;
`endif
      if (fire_req) begin
        free_s = find_free_slot(en_n);
        if (free_s.found) begin
          en_n[free_s.idx]   = 1'b1;
          life_n[free_s.idx] = life_t'(MISSILE_FRAMES);
          cd_n               = life_t'(FIRE_COOLDOWN);
          lp_n               = 1'b1;
          slot_n             = free_s.idx;
        end else begin
          drop_n = 1'b1;
        end
        pend_n = 1'b0;
      end
    end
    if (fire_rise && (cd_n == '0) && !pend_n) pend_n = 1'b1;
  end

  always_ff @(posedge vga_clk_i) begin
    if (vga_rst_i) begin
      vs_s1         <= 1'b0;
      vs_s2         <= 1'b0;
      vs_d          <= 1'b0;
      tick          <= 1'b0;
      fire_prev     <= 1'b0;
      btn_col       <= COL_RESET;
      btn_missle_en <= '0;
      for (int i = 0; i < NUM_MISSILES; i++) life[i] <= '0;
      cooldown      <= '0;
      pending       <= 1'b0;
      launch_pulse  <= 1'b0;
      launch_slot   <= '0;
      shot_dropped  <= 1'b0;
    end else begin
      vs_s1         <= vga_vs;
      vs_s2         <= vs_s1;
      vs_d          <= vs_s2;
      tick          <= vs_edge;
      fire_prev     <= fire_db;
      btn_col       <= col_n;
      btn_missle_en <= en_n;
      life          <= life_n;
      cooldown      <= cd_n;
      pending       <= pend_n;
      launch_pulse  <= lp_n;
      launch_slot   <= slot_n;
      shot_dropped  <= drop_n;
    end
  end

endmodule

// File: tb/tb_player_input_ctrl.sv
// Scoreboard bench for player_input_ctrl: two instances (short and long missile
// life), expected outputs queued per frame and checked by a monitor.
module tb_player_input_ctrl;

  localparam int W = 25;  // {col[11:0], en[7:0], launch_pulse, launch_slot[2:0], shot_dropped}

  logic vga_clk_i = 1'b0;
  always #5 vga_clk_i = ~vga_clk_i;

  logic vga_rst_i = 1'b1;
  logic vga_vs    = 1'b1;
  logic left1 = 1'b0, right1 = 1'b0, fire1 = 1'b0;
  logic fire2 = 1'b0;
  logic zero2 = 1'b0;

  logic [11:0] col1, col2;
  logic [7:0]  en1, en2;
  logic        lp1, lp2, drop1, drop2;
  logic [2:0]  slot1, slot2;

  player_input_ctrl #(
    .DEBOUNCE_CYCLES(4), .MISSILE_FRAMES(3), .FIRE_COOLDOWN(1)
  ) dut (
    .vga_clk_i(vga_clk_i), .vga_rst_i(vga_rst_i), .vga_vs(vga_vs),
    .btn_left_i(left1), .btn_right_i(right1), .btn_fire_i(fire1),
    .btn_col(col1), .btn_missle_en(en1), .launch_pulse(lp1),
    .launch_slot(slot1), .shot_dropped(drop1)
  );

  player_input_ctrl #(
    .DEBOUNCE_CYCLES(4), .MISSILE_FRAMES(20), .FIRE_COOLDOWN(0)
  ) dut2 (
    .vga_clk_i(vga_clk_i), .vga_rst_i(vga_rst_i), .vga_vs(vga_vs),
    .btn_left_i(zero2), .btn_right_i(zero2), .btn_fire_i(fire2),
    .btn_col(col2), .btn_missle_en(en2), .launch_pulse(lp2),
    .launch_slot(slot2), .shot_dropped(drop2)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp2_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  event snap_ev;

  function automatic logic [W-1:0] pk(input logic [11:0] c, input logic [7:0] e,
                                      input logic lp, input logic [2:0] s, input logic d);
    return {c, e, lp, s, d};
  endfunction

  task automatic check_one(input string nm, input logic [W-1:0] expv, input logic [W-1:0] act);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got col=%0d en=%h lp=%b slot=%0d drop=%b, want col=%0d en=%h lp=%b slot=%0d drop=%b",
               nm, act[24:13], act[12:5], act[4], act[3:1], act[0],
               expv[24:13], expv[12:5], expv[4], expv[3:1], expv[0]);
    end
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL %s dut1: no expected entry queued", tag);
    end else begin
      check_one({tag, " dut1"}, exp_q.pop_front(), pk(col1, en1, lp1, slot1, drop1));
    end
    if (exp2_q.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL %s dut2: no expected entry queued", tag);
    end else begin
      check_one({tag, " dut2"}, exp2_q.pop_front(), pk(col2, en2, lp2, slot2, drop2));
    end
  endtask

  // Monitor: outputs are presented four clocks after the falling vs edge is driven.
  initial begin
    forever begin
      @(negedge vga_vs);
      repeat (4) @(posedge vga_clk_i);
      #1;
      pop_check("frame");
    end
  end

  initial begin
    forever begin
      @(snap_ev);
      pop_check("snap");
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge vga_clk_i);
  endtask

  task automatic frame(input logic [W-1:0] x1, input logic [W-1:0] x2);
    exp_q.push_back(x1);
    exp2_q.push_back(x2);
    cyc(24);
    vga_vs = 1'b0;
    cyc(8);
    vga_vs = 1'b1;
  endtask

  int         c1;
  logic [7:0] e2;

  initial begin
    c1 = 312;
    e2 = 8'h00;
    cyc(5);
    vga_rst_i = 1'b0;
    cyc(3);
    exp_q.push_back(pk(12'd312, 8'h00, 1'b0, 3'd0, 1'b0));
    exp2_q.push_back(pk(12'd312, 8'h00, 1'b0, 3'd0, 1'b0));
    -> snap_ev;
    cyc(1);
    frame(pk(12'd312, 8'h00, 0, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));

    // Two-cycle glitch on right must not move the player.
    right1 = 1'b1; cyc(2); right1 = 1'b0; cyc(4);
    frame(pk(12'd312, 8'h00, 0, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));
    right1 = 1'b1;
    frame(pk(12'd316, 8'h00, 0, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));
    right1 = 1'b0;
    c1 = 316;
    frame(pk(12'd316, 8'h00, 0, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));

    // Hold left long enough to hit the left clamp and sit there.
    left1 = 1'b1;
    for (int k = 0; k < 80; k++) begin
      c1 = (c1 - 4 < 16) ? 16 : c1 - 4;
      frame(pk(12'(c1), 8'h00, 0, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));
    end
    right1 = 1'b1;
    frame(pk(12'd16, 8'h00, 0, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));
    frame(pk(12'd16, 8'h00, 0, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));
    left1 = 1'b0;
    frame(pk(12'd20, 8'h00, 0, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));
    right1 = 1'b0;
    frame(pk(12'd20, 8'h00, 0, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));

    // Missile life of three frames.
    fire1 = 1'b1;
    frame(pk(12'd20, 8'h01, 1, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));
    fire1 = 1'b0;
    frame(pk(12'd20, 8'h01, 0, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));
    frame(pk(12'd20, 8'h01, 0, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));
    frame(pk(12'd20, 8'h00, 0, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));

    // Press during cooldown is ignored, holding does not refire, then same-tick reuse of slot 0.
    fire1 = 1'b1;
    frame(pk(12'd20, 8'h01, 1, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));
    fire1 = 1'b0; cyc(10); fire1 = 1'b1;
    frame(pk(12'd20, 8'h01, 0, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));
    frame(pk(12'd20, 8'h01, 0, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));
    fire1 = 1'b0; cyc(10); fire1 = 1'b1;
    frame(pk(12'd20, 8'h01, 1, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));
    fire1 = 1'b0;
    frame(pk(12'd20, 8'h01, 0, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));
    frame(pk(12'd20, 8'h01, 0, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));
    frame(pk(12'd20, 8'h00, 0, 0, 0), pk(12'd312, 8'h00, 0, 0, 0));

    // Four long-lived missiles on dut2, then a one-cycle reset mid-flight.
    for (int n = 0; n < 4; n++) begin
      fire2 = 1'b1;
      e2[n] = 1'b1;
      frame(pk(12'd20, 8'h00, 0, 0, 0), pk(12'd312, e2, 1, 3'(n), 0));
      fire2 = 1'b0;
      cyc(10);
    end
    vga_rst_i = 1'b1;
    @(posedge vga_clk_i);
    #1;
    exp_q.push_back(pk(12'd312, 8'h00, 1'b0, 3'd0, 1'b0));
    exp2_q.push_back(pk(12'd312, 8'h00, 1'b0, 3'd0, 1'b0));
    -> snap_ev;
    @(negedge vga_clk_i);
    vga_rst_i = 1'b0;
    cyc(4);

    // Fill all eight slots, then the ninth shot is dropped.
    e2 = 8'h00;
    for (int n = 0; n < 9; n++) begin
      fire2 = 1'b1;
      if (n < 8) begin
        e2[n] = 1'b1;
        frame(pk(12'd312, 8'h00, 0, 0, 0), pk(12'd312, e2, 1, 3'(n), 0));
      end else begin
        frame(pk(12'd312, 8'h00, 0, 0, 0), pk(12'd312, 8'hFF, 0, 0, 1));
      end
      fire2 = 1'b0;
      cyc(10);
    end
    frame(pk(12'd312, 8'h00, 0, 0, 0), pk(12'd312, 8'hFF, 0, 0, 0));

    cyc(10);
    vectors++;
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: %0d/%0d expected entries never checked, want 0/0",
               exp_q.size(), exp2_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
